// File: rtl/logic_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the 8-bit logic unit.
package logic_arb_pkg;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/logic_unit.sv
// 8-bit bitwise logic unit: AND / OR / XOR / NOT A, selected by op.
module logic_unit import logic_arb_pkg::*; (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);
  logic [DATA_W-1:0] w_and, w_or, w_xor, w_not;

  assign w_and = i_a & i_b;
  assign w_or  = i_a | i_b;
  assign w_xor = i_a ^ i_b;
  assign w_not = ~i_a;

  always_comb begin
    o_y = w_not;
    case (i_op)
      OP_AND:  o_y = w_and;
      OP_OR:   o_y = w_or;
      OP_XOR:  o_y = w_xor;
      default: o_y = w_not;
    endcase
  end
endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);
  int             w_t;
  logic [ID_W-1:0] w_j;

  // Walk offsets high to low so the smallest offset from i_ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_t   = 0;
    w_j   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_t = (int'(i_ptr) + k) % N_REQ;
      w_j = w_t[ID_W-1:0];
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign o_any = |i_req;
endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one logic unit among N_REQ requesters, one op in flight.
// Optional LOGIC_ARB_FLAGS_EN adds registered rsp_zero / rsp_parity outputs.
module logic_unit_arbiter import logic_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [2*N_REQ-1:0]    i_req_op,
  input  logic [8*N_REQ-1:0]    i_req_a,
  input  logic [8*N_REQ-1:0]    i_req_b,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [DATA_W-1:0]     o_rsp_data,
`ifdef LOGIC_ARB_FLAGS_EN
  output logic                  o_rsp_zero,
  output logic                  o_rsp_parity,
`endif
  output logic                  o_busy
);
  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr, r_gid, r_rsp_id;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_rsp_data;
  logic              r_rsp_valid;
`ifdef LOGIC_ARB_FLAGS_EN
  logic              r_rsp_zero, r_rsp_parity;
`endif

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_idx, w_ptr_nxt;
  logic              w_any;
  logic [DATA_W-1:0] w_y;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  logic_unit u_lu (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_y)
  );

  assign w_ptr_nxt   = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign o_req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
`ifdef LOGIC_ARB_FLAGS_EN
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_parity = r_rsp_parity;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_op        <= OP_AND;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
`ifdef LOGIC_ARB_FLAGS_EN
      r_rsp_zero   <= 1'b0;
      r_rsp_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_op     <= i_req_op[w_idx*2 +: 2];
          r_a      <= i_req_a[w_idx*DATA_W +: DATA_W];
          r_b      <= i_req_b[w_idx*DATA_W +: DATA_W];
          r_gid    <= w_idx;
          r_rr_ptr <= w_ptr_nxt;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_rsp_data  <= w_y;
          r_rsp_id    <= r_gid;
          r_rsp_valid <= 1'b1;
`ifdef LOGIC_ARB_FLAGS_EN
          r_rsp_zero   <= (w_y == '0);
          r_rsp_parity <= ^w_y;
`endif
          r_state     <= ST_RESP;
        end
        ST_RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (N_REQ=4).
module tb_logic_unit_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
`ifdef LOGIC_ARB_FLAGS_EN
  logic        rsp_zero, rsp_parity;
`endif

  int checks = 0;
  int fails  = 0;

  logic_unit_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
`ifdef LOGIC_ARB_FLAGS_EN
    .o_rsp_zero   (rsp_zero),
    .o_rsp_parity (rsp_parity),
`endif
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rsp_id !== 2'd0 || rsp_data !== 8'h00) begin
        $display("FAIL reset_idle c=%0d: ready=%b valid=%b busy=%b id=%0d data=%h, want 0000 0 0 0 00",
                 c, req_ready, rsp_valid, busy, rsp_id, rsp_data);
        fails++;
      end
    end
  endtask

  task automatic test_single_op();
    logic [1:0] ops [4];
    logic [7:0] exp [4];
    ops = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 set_req(1, ops[k], 8'hF0, 8'h3C);
      req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
        $display("FAIL single_grant op=%0d: ready=%b want 0010", k, req_ready); fails++;
      end
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL single_exec op=%0d: valid=%b busy=%b want 0 1", k, rsp_valid, busy); fails++;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[k] || rsp_id !== 2'd1) begin
        $display("FAIL single_rsp op=%0d: valid=%b data=%h id=%0d want 1 %h 1",
                 k, rsp_valid, rsp_data, rsp_id, exp[k]); fails++;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL single_done op=%0d: valid=%b busy=%b want 0 0", k, rsp_valid, busy); fails++;
      end
    end
  endtask

  task automatic test_contention();
    logic [3:0] gnts [$];
    int         gcyc [$];
    logic [1:0] ids  [$];
    logic [7:0] dats [$];
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
    do_reset();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'hF0, 8'h3C);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (|req_ready) begin gnts.push_back(req_ready); gcyc.push_back(c); end
      if (rsp_valid) begin ids.push_back(rsp_id); dats.push_back(rsp_data); end
    end
    @(posedge clk);
    #1 req_valid = '0;
    checks++;
    if (gnts.size() != 5 || ids.size() != 5) begin
      $display("FAIL contention_count: grants=%0d rsps=%0d want 5 5", gnts.size(), ids.size());
      fails++;
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gnts[k] !== exp_g[k] || ids[k] !== 2'(k % 4) || dats[k] !== exp_d[k % 4]) begin
          $display("FAIL contention_%0d: gnt=%b id=%0d data=%h want %b %0d %h",
                   k, gnts[k], ids[k], dats[k], exp_g[k], k % 4, exp_d[k % 4]);
          fails++;
        end
        if (k > 0) begin
          checks++;
          if (gcyc[k] - gcyc[k-1] != 3) begin
            $display("FAIL contention_spacing_%0d: got %0d cycles want 3", k, gcyc[k] - gcyc[k-1]);
            fails++;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Pointer is 1 on entry (last grant was 0), so requester 2 wins.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 set_req(2, 2'b10, 8'h55, 8'hFF);
    set_req(3, 2'b00, 8'hFF, 8'h81);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL bp_grant: ready=%b want 0100", req_ready); fails++;
    end
    @(posedge clk);
    #1 req_valid = 4'b1000;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hAA || rsp_id !== 2'd2 || req_ready !== 4'b0) begin
        $display("FAIL bp_hold c=%0d: valid=%b data=%h id=%0d ready=%b want 1 aa 2 0000",
                 c, rsp_valid, rsp_data, rsp_id, req_ready); fails++;
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL bp_release_hold: valid=%b want 1", rsp_valid); fails++;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      $display("FAIL bp_resume: valid=%b ready=%b want 0 1000", rsp_valid, req_ready); fails++;
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || rsp_id !== 2'd3) begin
      $display("FAIL bp_next: valid=%b data=%h id=%0d want 1 81 3", rsp_valid, rsp_data, rsp_id);
      fails++;
    end
    @(negedge clk);
  endtask

  // Pointer is 0 on entry; granting 2 moves it to 3 before the reset.
  task automatic test_reset_mid_op();
    @(posedge clk);
    #1 set_req(2, 2'b01, 8'h11, 8'h22);
    req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL rst_mid_exec: busy=%b want 1", busy); fails++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || rsp_data !== 8'h00) begin
      $display("FAIL rst_mid_clear: valid=%b busy=%b ready=%b data=%h want 0 0 0000 00",
               rsp_valid, busy, req_ready, rsp_data); fails++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL rst_mid_norsp c=%0d: valid=%b busy=%b want 0 0", c, rsp_valid, busy); fails++;
      end
    end
    @(posedge clk);
    #1 set_req(1, 2'b00, 8'hFF, 8'h0F);
    set_req(3, 2'b00, 8'hFF, 8'hF0);
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL rst_mid_ptr: ready=%b want 0010", req_ready); fails++;
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flags();
`ifdef LOGIC_ARB_FLAGS_EN
    logic [1:0] ops [2];
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [7:0] ed [2];
    logic       ez [2];
    ops = '{2'b10, 2'b01};
    av  = '{8'hA5, 8'h01};
    bv  = '{8'hA5, 8'h02};
    ed  = '{8'h00, 8'h03};
    ez  = '{1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 set_req(0, ops[k], av[k], bv[k]);
      req_valid = 4'b0001;
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ed[k] || rsp_zero !== ez[k] || rsp_parity !== 1'b0) begin
        $display("FAIL flags_%0d: valid=%b data=%h zero=%b parity=%b want 1 %h %b 0",
                 k, rsp_valid, rsp_data, rsp_zero, rsp_parity, ed[k], ez[k]); fails++;
      end
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_reset_mid_op();
    test_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
